// File: rtl/console_pkg.sv
// Shared register map and bit positions for the multi-channel console.
package console_pkg;

  typedef enum logic [1:0] {
    REG_SETUP = 2'd0,
    REG_FIFO  = 2'd1,
    REG_RX    = 2'd2,
    REG_TX    = 2'd3
  } reg_e;

  localparam int BIT_EMPTY = 8;
  localparam int BIT_FULL  = 9;
  localparam int BIT_OVF   = 12;
  localparam int BIT_HALF  = 13;

  localparam int SETUP_TXRST = 0;
  localparam int SETUP_RXRST = 1;
  localparam int SETUP_RXIE  = 2;
  localparam int SETUP_TXIE  = 3;

  function automatic int calc_aw(input int nch);
    return 2 + $clog2(nch);
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO with fall-through head, fill count and sync clear.
module console_fifo #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [BW-1:0]     i_data,
  input  logic              i_pop,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [LGFLEN:0]   o_count
);

  localparam int DEPTH = 1 << LGFLEN;

  logic [BW-1:0]   mem [DEPTH];
  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign o_count = wr_ptr - rd_ptr;
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = o_count[LGFLEN];
  assign do_pop  = i_pop & !o_empty;
  // a full FIFO still takes a push when the head leaves this cycle
  assign do_push = i_push & (!o_full | do_pop);
  assign o_data  = mem[rd_ptr[LGFLEN-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clr) mem[wr_ptr[LGFLEN-1:0]] <= i_data;
  end

endmodule

// File: rtl/console_nch.sv
// Multi-channel Wishbone console: per-channel RX/TX FIFOs,
// interrupt enables, sticky overflow flags and fill status.
module console_nch
  import console_pkg::*;
#(
  parameter int NCH    = 1,
  parameter int BW     = 8,
  parameter int LGFLEN = 4,
  localparam int AW    = calc_aw(NCH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic [31:0]       o_wb_data,
  output logic [NCH-1:0]    o_console_stb,
  output logic [NCH*BW-1:0] o_console_data,
  input  logic [NCH-1:0]    i_console_busy,
  input  logic [NCH-1:0]    i_console_stb,
  input  logic [NCH*BW-1:0] i_console_data,
  output logic [NCH-1:0]    o_rx_int,
  output logic [NCH-1:0]    o_tx_int,
  output logic              o_int
);

  localparam int CW   = (AW > 2) ? AW - 2 : 1;
  localparam int HALF = 1 << (LGFLEN - 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic          acc;
  logic [CW-1:0] ch;
  reg_e          rsel;
  logic [31:0]   rd_word [NCH];
  logic [31:0]   rdata;
  logic          ack_q;
  logic          unused;

  // assert asynchronously, release two clocks after i_rst_n rises
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign acc  = i_wb_cyc & i_wb_stb;
  assign rsel = reg_e'(i_wb_addr[1:0]);

  generate
    if (AW > 2) begin : g_chsel
      assign ch = i_wb_addr[AW-1:2];
    end else begin : g_chsel0
      assign ch = '0;
    end
  endgenerate

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      logic            sel;
      logic            setup_wr;
      logic            rx_rd;
      logic            tx_wr;
      logic            rx_clr;
      logic            tx_clr;
      logic            tx_pop;
      logic            rx_empty;
      logic            rx_full;
      logic            tx_empty;
      logic            tx_full;
      logic [LGFLEN:0] rx_cnt;
      logic [LGFLEN:0] tx_cnt;
      logic [BW-1:0]   rx_head;
      logic [BW-1:0]   tx_head;
      logic [BW-1:0]   tx_last;
      logic            rx_ie;
      logic            tx_ie;
      logic            rx_ovf;
      logic            tx_ovf;
      logic [31:0]     word;

      assign sel      = acc & (ch == CW'(c));
      assign setup_wr = sel & i_wb_we & (rsel == REG_SETUP);
      assign rx_rd    = sel & !i_wb_we & (rsel == REG_RX);
      assign tx_wr    = sel & i_wb_we & (rsel == REG_TX);
      assign tx_clr   = setup_wr & i_wb_data[SETUP_TXRST];
      assign rx_clr   = setup_wr & i_wb_data[SETUP_RXRST];
      assign tx_pop   = !tx_empty & !i_console_busy[c];

      console_fifo #(.BW(BW), .LGFLEN(LGFLEN)) u_rx (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_clr   (rx_clr),
        .i_push  (i_console_stb[c]),
        .i_data  (i_console_data[c*BW +: BW]),
        .i_pop   (rx_rd),
        .o_data  (rx_head),
        .o_empty (rx_empty),
        .o_full  (rx_full),
        .o_count (rx_cnt)
      );

      console_fifo #(.BW(BW), .LGFLEN(LGFLEN)) u_tx (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_clr   (tx_clr),
        .i_push  (tx_wr),
        .i_data  (i_wb_data[BW-1:0]),
        .i_pop   (tx_pop),
        .o_data  (tx_head),
        .o_empty (tx_empty),
        .o_full  (tx_full),
        .o_count (tx_cnt)
      );

      // a flag raised in the same cycle as its clear stays raised
      always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
          rx_ie   <= 1'b0;
          tx_ie   <= 1'b0;
          rx_ovf  <= 1'b0;
          tx_ovf  <= 1'b0;
          tx_last <= '0;
        end else begin
          if (setup_wr) begin
            rx_ie <= i_wb_data[SETUP_RXIE];
            tx_ie <= i_wb_data[SETUP_TXIE];
          end
          if (tx_wr) tx_last <= i_wb_data[BW-1:0];
          rx_ovf <= (i_console_stb[c] & rx_full & !rx_rd)
                  | (rx_ovf & !(rx_rd | rx_clr));
          tx_ovf <= (tx_wr & tx_full & !tx_pop)
                  | (tx_ovf & !tx_clr);
        end
      end

      always_comb begin
        word = '0;
        unique case (1'b1)
          rsel == REG_SETUP: begin
            word[SETUP_RXIE] = rx_ie;
            word[SETUP_TXIE] = tx_ie;
          end
          rsel == REG_FIFO: begin
            word = {4'(LGFLEN), 1'b0, 11'(tx_cnt),
                    4'(LGFLEN), 1'b0, 11'(rx_cnt)};
          end
          rsel == REG_RX: begin
            if (!rx_empty) word[BW-1:0] = rx_head;
            word[BIT_EMPTY] = rx_empty;
            word[BIT_OVF]   = rx_ovf;
            word[BIT_HALF]  = (rx_cnt >= HALF[LGFLEN:0]);
          end
          rsel == REG_TX: begin
            word[BW-1:0]    = tx_last;
            word[BIT_EMPTY] = i_console_busy[c] | !tx_empty;
            word[BIT_FULL]  = tx_full;
            word[BIT_OVF]   = tx_ovf;
            word[BIT_HALF]  = (tx_cnt < HALF[LGFLEN:0]);
          end
          default: ;
        endcase
      end

      assign rd_word[c]                  = word;
      assign o_console_stb[c]            = !tx_empty;
      assign o_console_data[c*BW +: BW]  = tx_head;
      assign o_rx_int[c]                 = rx_ie & !rx_empty;
      assign o_tx_int[c]                 = tx_ie & (tx_cnt < HALF[LGFLEN:0]);
    end
  endgenerate

  // channels beyond NCH fall through to zero
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch == CW'(c)) rdata = rd_word[c];
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      o_wb_data <= '0;
    end else begin
      ack_q <= acc;
      if (acc) o_wb_data <= i_wb_we ? 32'h0 : rdata;
    end
  end

  assign o_wb_ack   = ack_q & i_wb_cyc;
  assign o_wb_stall = 1'b0;
  assign o_int      = |{o_rx_int, o_tx_int};
  assign unused     = ^{1'b0, i_wb_data[31:BW]};

endmodule

// File: tb/tb_console_nch.sv
// Scoreboard bench: a 3-channel depth-16 console and a
// 1-channel depth-4 console share the bus wires.
module tb_console_nch;

  localparam int NCH = 3;
  localparam int BW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, stb_s = 1'b0, we = 1'b0;
  logic [3:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic ack, stall, ack_s, stall_s;
  logic [31:0] rdata, rdata_s;
  logic [NCH-1:0] con_stb, rx_int, tx_int;
  logic [NCH-1:0] busy = '1;
  logic [NCH-1:0] rx_stb = '0;
  logic [NCH*BW-1:0] con_data;
  logic [NCH*BW-1:0] rx_data = '0;
  logic irq;
  logic con_stb_s, rx_int_s, tx_int_s, irq_s;
  logic busy_s = 1'b1, rx_stb_s = 1'b0;
  logic [7:0] con_data_s;
  logic [7:0] rx_data_s = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  mon_exp;

  console_nch #(.NCH(NCH), .BW(BW), .LGFLEN(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
    .o_console_stb(con_stb), .o_console_data(con_data),
    .i_console_busy(busy), .i_console_stb(rx_stb),
    .i_console_data(rx_data),
    .o_rx_int(rx_int), .o_tx_int(tx_int), .o_int(irq)
  );

  console_nch #(.NCH(1), .BW(BW), .LGFLEN(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb_s), .i_wb_we(we),
    .i_wb_addr(addr[1:0]), .i_wb_data(wdata),
    .o_wb_ack(ack_s), .o_wb_stall(stall_s), .o_wb_data(rdata_s),
    .o_console_stb(con_stb_s), .o_console_data(con_data_s),
    .i_console_busy(busy_s), .i_console_stb(rx_stb_s),
    .i_console_data(rx_data_s),
    .o_rx_int(rx_int_s), .o_tx_int(tx_int_s), .o_int(irq_s)
  );

  // TX stream scoreboard on the big console, channel 0
  always @(negedge clk) begin
    if (rst_n && con_stb[0] && !busy[0]) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected got=%h exp=none", con_data[7:0]);
      end else begin
        mon_exp = tx_q.pop_front();
        if (con_data[7:0] !== mon_exp) begin
          failures++;
          $display("FAIL tx_char got=%h exp=%h", con_data[7:0], mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus(input bit s, input bit w, input logic [3:0] a,
                     input logic [31:0] d, input bit drop,
                     output logic [31:0] q, output logic k);
    @(posedge clk); #1;
    cyc = 1'b1; stb = !s; stb_s = s;
    we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    stb = 1'b0; stb_s = 1'b0; we = 1'b0;
    if (drop) cyc = 1'b0;
    @(negedge clk);
    q = s ? rdata_s : rdata;
    k = s ? ack_s : ack;
    cyc = 1'b0;
  endtask

  task automatic wr(input bit s, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    logic k;
    bus(s, 1'b1, a, d, 1'b0, q, k);
  endtask

  task automatic rx_push(input bit s, input int c, input logic [7:0] v);
    @(posedge clk); #1;
    if (s) begin
      rx_stb_s = 1'b1; rx_data_s = v;
    end else begin
      rx_stb[c] = 1'b1; rx_data[c*BW +: BW] = v;
    end
    @(posedge clk); #1;
    rx_stb = '0; rx_stb_s = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    logic k;
    bit s [4];
    logic [3:0] ra [4];
    logic [31:0] ex [4];
    s  = '{1'b0, 1'b1, 1'b0, 1'b0};
    ra = '{4'h1, 4'h1, 4'hD, 4'hF};
    ex = '{32'h4000_4000, 32'h2000_2000, 32'h0, 32'h0};
    @(negedge clk);
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; stb_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, ack_s, con_stb, con_stb_s, irq, irq_s, stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {ack, ack_s, con_stb, con_stb_s, irq, irq_s, stall});
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    cyc = 1'b0; stb = 1'b0; stb_s = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    wr(1'b0, 4'hC, 32'hC);
    wr(1'b0, 4'hF, 32'h99);
    checks++;
    if ({con_stb, irq} !== '0) begin
      failures++;
      $display("FAIL bad_channel_write got=%b exp=0", {con_stb, irq});
    end
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(ex[i]);
      bus(s[i], 1'b0, ra[i], 32'h0, 1'b0, got, k);
      e = rd_q.pop_front();
      checks++;
      if (got !== e || k !== 1'b1) begin
        failures++;
        $display("FAIL reset_read%0d got=%h ack=%b exp=%h ack=1", i, got, k, e);
      end
    end
  endtask

  task automatic test_rx();
    logic [31:0] got, e;
    logic k;
    logic [2:0] ei [3];
    ei = '{3'b010, 3'b000, 3'b000};
    wr(1'b0, 4'h4, 32'h4);
    checks++;
    if (rx_int !== 3'b000) begin
      failures++;
      $display("FAIL rx_int_empty got=%b exp=000", rx_int);
    end
    rx_push(1'b0, 1, 8'h41);
    rx_push(1'b0, 1, 8'h42);
    checks++;
    if (rx_int !== 3'b010 || irq !== 1'b1) begin
      failures++;
      $display("FAIL rx_int_full got=%b/%b exp=010/1", rx_int, irq);
    end
    rd_q.push_back(32'h041);
    rd_q.push_back(32'h042);
    rd_q.push_back(32'h100);
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, 1'b0, 4'h6, 32'h0, 1'b0, got, k);
      e = rd_q.pop_front();
      checks++;
      if (got !== e || rx_int !== ei[i]) begin
        failures++;
        $display("FAIL rx_read%0d got=%h int=%b exp=%h int=%b",
                 i, got, rx_int, e, ei[i]);
      end
    end
    wr(1'b0, 4'h4, 32'h0);
  endtask

  task automatic test_rx_ovf();
    logic [31:0] got, e;
    logic k;
    logic [3:0] ra [4];
    logic [31:0] ex [4];
    for (int i = 0; i < 5; i++) rx_push(1'b1, 0, 8'h10 + 8'(i));
    ra = '{4'h1, 4'h2, 4'h2, 4'h1};
    ex = '{32'h2000_2004, 32'h3010, 32'h2011, 32'h2000_2003};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        rx_push(1'b1, 0, 8'h20);
        rx_push(1'b1, 0, 8'h21);
        ex[3] = 32'h2000_2004;
      end
      rd_q.push_back(ex[i]);
      bus(1'b1, 1'b0, ra[i], 32'h0, 1'b0, got, k);
      e = rd_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rx_ovf%0d got=%h exp=%h", i, got, e);
      end
    end
    // read and console push in the same cycle on a full FIFO
    rd_q.push_back(32'h2012);
    @(posedge clk); #1;
    cyc = 1'b1; stb_s = 1'b1; we = 1'b0; addr = 4'h2;
    rx_stb_s = 1'b1; rx_data_s = 8'h22;
    @(posedge clk); #1;
    stb_s = 1'b0; rx_stb_s = 1'b0;
    @(negedge clk);
    got = rdata_s;
    cyc = 1'b0;
    e = rd_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL rx_pushpop got=%h exp=%h", got, e);
    end
    ra = '{4'h1, 4'h2, 4'h1, 4'h2};
    ex = '{32'h2000_2004, 32'h2013, 32'h2000_2000, 32'h100};
    for (int i = 0; i < 4; i++) begin
      if (i == 2) wr(1'b1, 4'h0, 32'h2);
      rd_q.push_back(ex[i]);
      bus(1'b1, 1'b0, ra[i], 32'h0, 1'b0, got, k);
      e = rd_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rx_after%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_tx();
    logic [31:0] got, e;
    logic k;
    busy[0] = 1'b1;
    tx_q.push_back(8'h55);
    wr(1'b0, 4'h3, 32'h55);
    checks++;
    if (con_stb[0] !== 1'b1 || con_data[7:0] !== 8'h55) begin
      failures++;
      $display("FAIL tx_first got=%b/%h exp=1/55", con_stb[0], con_data[7:0]);
    end
    tx_q.push_back(8'hAA);
    wr(1'b0, 4'h3, 32'hAA);
    rd_q.push_back(32'h21AA);
    bus(1'b0, 1'b0, 4'h3, 32'h0, 1'b0, got, k);
    e = rd_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL tx_reg got=%h exp=%h", got, e);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      busy[0] = 1'b0;
      @(posedge clk); #1;
      busy[0] = 1'b1;
      if (i == 0) begin
        checks++;
        if (con_stb[0] !== 1'b1 || con_data[7:0] !== 8'hAA) begin
          failures++;
          $display("FAIL tx_second got=%b/%h exp=1/aa", con_stb[0], con_data[7:0]);
        end
      end
    end
    checks++;
    if (con_stb[0] !== 1'b0 || tx_q.size() != 0) begin
      failures++;
      $display("FAIL tx_drain got=%b/%0d exp=0/0", con_stb[0], tx_q.size());
    end
    wr(1'b0, 4'h0, 32'hB);
    rd_q.push_back(32'h8);
    bus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, got, k);
    e = rd_q.pop_front();
    checks++;
    if (got !== e || tx_int !== 3'b001) begin
      failures++;
      $display("FAIL tx_setup got=%h/%b exp=%h/001", got, tx_int, e);
    end
    wr(1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_tx_full();
    logic [31:0] got, e;
    logic k;
    logic [3:0] ra [4];
    logic [31:0] ex [4];
    busy_s = 1'b1;
    for (int i = 0; i < 5; i++) wr(1'b1, 4'h3, 32'h61 + 32'(i));
    ra = '{4'h3, 4'h1, 4'h3, 4'h1};
    ex = '{32'h1365, 32'h2004_2000, 32'h2165, 32'h2000_2000};
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wr(1'b1, 4'h0, 32'h1);
        checks++;
        if (con_stb_s !== 1'b0) begin
          failures++;
          $display("FAIL tx_softreset_stb got=%b exp=0", con_stb_s);
        end
      end
      rd_q.push_back(ex[i]);
      bus(1'b1, 1'b0, ra[i], 32'h0, 1'b0, got, k);
      e = rd_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL tx_full%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, e;
    logic k;
    wr(1'b0, 4'h8, 32'h8);
    busy[0] = 1'b1;
    tx_q.push_back(8'h77);
    wr(1'b0, 4'h3, 32'h77);
    rd_q.push_back(32'h2177);
    bus(1'b0, 1'b0, 4'h3, 32'h0, 1'b0, got, k);
    e = rd_q.pop_front();
    checks++;
    if (got !== e || irq !== 1'b1 || con_stb[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got=%h/%b/%b exp=%h/1/1", got, irq, con_stb[0], e);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (con_stb !== '0 || rdata !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b/%h/%b exp=000/0/0", con_stb, rdata, irq);
    end
    tx_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    bus(1'b0, 1'b0, 4'h1, 32'h0, 1'b1, got, k);
    checks++;
    if (k !== 1'b0) begin
      failures++;
      $display("FAIL cyc_drop_ack got=%b exp=0", k);
    end
    rd_q.push_back(32'h0);
    bus(1'b0, 1'b0, 4'h8, 32'h0, 1'b0, got, k);
    e = rd_q.pop_front();
    checks++;
    if (got !== e || k !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_setup got=%h/%b exp=%h/1", got, k, e);
    end
    rd_q.push_back(32'h4000_4000);
    bus(1'b0, 1'b0, 4'h1, 32'h0, 1'b0, got, k);
    e = rd_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL post_reset_fifo got=%h exp=%h", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_rx_ovf();
    test_tx();
    test_tx_full();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
